// File: rtl/hazard_unit_if.sv
// Handshake bundle between the pipeline control path and hazard_unit.
// Master is the pipeline side, slave is the hazard unit.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instruction;
  logic             id_reg_write;
  logic             id_mem_to_reg;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stale;
  logic             pc_hold;
  logic             ifid_hold;
  logic             flush;
  logic             freeze;
  logic [1:0]       cause;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_instruction, id_reg_write, id_mem_to_reg,
    output ex_branch_taken, mem_req, mem_ready,
    input  stale, pc_hold, ifid_hold, flush, freeze,
    input  cause, stall_cycles
  );

  modport slave (
    input  id_instruction, id_reg_write, id_mem_to_reg,
    input  ex_branch_taken, mem_req, mem_ready,
    output stale, pc_hold, ifid_hold, flush, freeze,
    output cause, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// RAW scoreboard and stall/flush/memwait sequencer for the 5-stage core.
// Define HAZARD_FORWARDING_EN to stall on load-use in EX only.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_unit_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } mode_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  slot_t            sb_ex, sb_mem, sb_wb;
  logic [CNT_W-1:0] cnt;
  mode_e            mode;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2;
  logic       hazard, memwait;
  logic       is_wait, is_flush, is_stall;
  logic       unused_bits;

  assign opcode = hz.id_instruction[6:0];
  assign rd     = hz.id_instruction[11:7];
  assign rs1    = hz.id_instruction[19:15];
  assign rs2    = hz.id_instruction[24:20];

  assign unused_bits = ^{hz.id_instruction[31:25],
                         hz.id_instruction[14:12],
                         sb_wb};

  always_comb begin
    use_rs1 = 1'b1;
    unique case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
      default: ;
    endcase
  end

  assign use_rs2 = (opcode == OP_BRANCH) ||
                   (opcode == OP_STORE) ||
                   (opcode == OP_OP);

  function automatic logic hit(slot_t s, logic u1,
                               logic u2, logic [4:0] r1,
                               logic [4:0] r2);
    return s.valid &&
      ((u1 && r1 != 5'd0 && r1 == s.rd) ||
       (u2 && r2 != 5'd0 && r2 == s.rd));
  endfunction

`ifdef HAZARD_FORWARDING_EN
  assign hazard = sb_ex.is_load &&
    hit(sb_ex, use_rs1, use_rs2, rs1, rs2);
`else
  // no write-through register file, so WB still conflicts
  assign hazard = hit(sb_ex, use_rs1, use_rs2, rs1, rs2) ||
                  hit(sb_mem, use_rs1, use_rs2, rs1, rs2) ||
                  hit(sb_wb, use_rs1, use_rs2, rs1, rs2);
`endif

  assign memwait  = hz.mem_req & ~hz.mem_ready;
  assign is_wait  = ~rst & memwait;
  assign is_flush = ~rst & ~memwait & hz.ex_branch_taken;
  assign is_stall = ~rst & ~memwait &
                    ~hz.ex_branch_taken & hazard;

  always_comb begin
    mode = RUN;
    unique case (1'b1)
      is_wait:  mode = MEMWAIT;
      is_flush: mode = FLUSH;
      is_stall: mode = STALL;
      default:  mode = RUN;
    endcase
  end

  assign hz.stale        = rst | is_flush | is_stall;
  assign hz.pc_hold      = is_wait | is_stall;
  assign hz.ifid_hold    = is_wait | is_stall;
  assign hz.flush        = is_flush;
  assign hz.freeze       = is_wait;
  assign hz.cause        = mode;
  assign hz.stall_cycles = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
      cnt    <= '0;
    end else begin
      if (!is_wait) begin
        sb_wb         <= sb_mem;
        sb_mem        <= sb_ex;
        sb_ex.valid   <= hz.id_reg_write && (rd != 5'd0) &&
                         !hz.stale;
        sb_ex.rd      <= rd;
        sb_ex.is_load <= hz.id_mem_to_reg;
      end
      if (hz.pc_hold && !(&cnt))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit against a queue-based model.
// Build with or without HAZARD_FORWARDING_EN; the model follows the same rule.
module tb_hazard_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_5_1  = 32'h0000_A283;
  localparam logic [31:0] ADD_652 = 32'h0022_8333;
  localparam logic [31:0] ADDI_5  = 32'h0010_0293;
  localparam logic [31:0] ADD_655 = 32'h0052_8333;
  localparam logic [31:0] ADDI_0  = 32'h0010_0013;
  localparam logic [31:0] ADD_600 = 32'h0000_0333;

`ifdef HAZARD_FORWARDING_EN
  localparam int LU_ST  = 1;
  localparam int ALU_ST = 0;
`else
  localparam int LU_ST  = 3;
  localparam int ALU_ST = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(16)) hz ();

  hazard_unit #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  ent_t        pipe[$];
  int          m_cnt;
  logic [1:0]  obs_cause;
  logic [15:0] obs_cnt;

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.rd = 0; e.ld = 0;
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_cnt = 0;
  endtask

  task automatic cycle(input logic [31:0] ins,
                       input bit rw, input bit m2r,
                       input bit br, input bit mrq,
                       input bit mrdy, input bit r);
    bit [6:0] op;
    bit       u1, u2, haz, h;
    int       mode;
    bit [6:0] exp;
    ent_t     n;
    @(negedge clk);
    rst                = r;
    hz.id_instruction  = ins;
    hz.id_reg_write    = rw;
    hz.id_mem_to_reg   = m2r;
    hz.ex_branch_taken = br;
    hz.mem_req         = mrq;
    hz.mem_ready       = mrdy;
    #1;
    op  = ins[6:0];
    u1  = !(op inside {7'h37, 7'h17, 7'h6f});
    u2  = op inside {7'h63, 7'h23, 7'h33};
    haz = 0;
    foreach (pipe[i]) begin
      h = pipe[i].v &&
        ((u1 && ins[19:15] != 0 && ins[19:15] == pipe[i].rd) ||
         (u2 && ins[24:20] != 0 && ins[24:20] == pipe[i].rd));
`ifdef HAZARD_FORWARDING_EN
      if (i == 0 && pipe[i].ld && h) haz = 1;
`else
      if (h) haz = 1;
`endif
    end
    if (r)                mode = 0;
    else if (mrq && !mrdy) mode = 3;
    else if (br)          mode = 2;
    else if (haz)         mode = 1;
    else                  mode = 0;
    // {stale, pc_hold, ifid_hold, flush, freeze, cause}
    case (mode)
      1:       exp = {5'b11100, 2'd1};
      2:       exp = {5'b10010, 2'd2};
      3:       exp = {5'b01101, 2'd3};
      default: exp = {r, 4'b0000, 2'd0};
    endcase
    chk("strobes", {hz.stale, hz.pc_hold, hz.ifid_hold,
                    hz.flush, hz.freeze, hz.cause}, exp);
    chk("stall_cycles", hz.stall_cycles, m_cnt);
    obs_cause = hz.cause;
    obs_cnt   = hz.stall_cycles;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (mode != 3) begin
        n.v  = (mode == 0) && rw && ins[11:7] != 0;
        n.rd = ins[11:7];
        n.ld = m2r;
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
      if ((mode == 1 || mode == 3) && m_cnt < 65535)
        m_cnt++;
    end
  endtask

  task automatic run_pair(string tag, logic [31:0] i1,
                          bit m2r1, logic [31:0] i2,
                          int exp_st);
    int base, n;
    cycle(NOP, 0, 0, 0, 0, 1, 1);
    cycle(i1, 1, m2r1, 0, 0, 1, 0);
    base = m_cnt;
    n    = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(i2, 1, 0, 0, 0, 1, 0);
      if (obs_cause == 2'd1) n++;
      else break;
    end
    chk({tag, "_stalls"}, n, exp_st);
    #1 chk({tag, "_cnt"}, hz.stall_cycles, base + exp_st);
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [31:0] ins;
    int base;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
            7'h03, 7'h23, 7'h13, 7'h33};

    rst = 1'b1;
    hz.id_instruction  = NOP;
    hz.id_reg_write    = 0;
    hz.id_mem_to_reg   = 0;
    hz.ex_branch_taken = 0;
    hz.mem_req         = 0;
    hz.mem_ready       = 1;
    @(posedge clk);
    model_reset();

    cycle(ADD_652, 1, 0, 1, 1, 0, 1);
    chk("reset_cause", obs_cause, 0);

    run_pair("load_use", LW_5_1, 1, ADD_652, LU_ST);
    run_pair("alu_use", ADDI_5, 0, ADD_655, ALU_ST);
    run_pair("x0", ADDI_0, 0, ADD_600, 0);

    cycle(NOP, 0, 0, 0, 0, 1, 1);
    cycle(LW_5_1, 1, 1, 0, 0, 1, 0);
    cycle(ADD_652, 1, 0, 1, 0, 1, 0);
    chk("br_vs_hazard", obs_cause, 2);
    cycle(NOP, 1, 0, 0, 0, 1, 0);
    chk("br_next_run", obs_cause, 0);

    cycle(NOP, 0, 0, 0, 0, 1, 1);
    base = m_cnt;
    for (int k = 0; k < 4; k++) begin
      cycle(NOP, 1, 0, 1, 1, 0, 0);
      chk("memwait_cause", obs_cause, 3);
    end
    cycle(NOP, 1, 0, 1, 1, 1, 0);
    chk("memwait_then_flush", obs_cause, 2);
    #1 chk("memwait_cnt", hz.stall_cycles, base + 4);

    cycle(NOP, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3000; k++) begin
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      cycle(ins, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0);
    end

    cycle(NOP, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 65534; k++)
      cycle(NOP, 0, 0, 0, 1, 0, 0);
    #1 chk("cnt_fffe", hz.stall_cycles, 16'hFFFE);
    for (int k = 0; k < 3; k++)
      cycle(NOP, 0, 0, 0, 1, 0, 0);
    #1 chk("cnt_sat", hz.stall_cycles, 16'hFFFF);
    cycle(NOP, 0, 0, 0, 1, 0, 1);
    cycle(NOP, 0, 0, 0, 0, 1, 0);
    chk("rst_mid_cnt", obs_cnt, 0);
    chk("rst_mid_cause", obs_cause, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard scheduler for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It tracks destination registers of in-flight instructions in a 3-entry scoreboard and detects read-after-write hazards against the instruction in ID. It sequences stalls, branch flushes and data-memory wait states. It drives the `stale` input of the decoder plus the pipeline-register hold/flush/freeze strobes.

## Interface
- `CNT_W`, 16: width of the saturating stall-cycle counter.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_instruction` in 32: instruction currently in ID.
- `id_reg_write` in 1: decoder `reg_write_enable` for the ID instruction.
- `id_mem_to_reg` in 1: decoder `mem_to_reg` for the ID instruction (load).
- `ex_branch_taken` in 1: branch in EX resolved taken; PC redirect this cycle.
- `mem_req` in 1: instruction in MEM accesses data memory.
- `mem_ready` in 1: data memory completes access this cycle.
- `stale` out 1: to decoder; the ID instruction becomes a bubble into EX.
- `pc_hold` out 1: PC keeps its value.
- `ifid_hold` out 1: IF/ID register keeps its value.
- `flush` out 1: IF/ID register is cleared to NOP at the next edge.
- `freeze` out 1: ID/EX, EX/MEM and MEM/WB registers keep their values.
- `cause` out 2: current-cycle mode: 0 RUN, 1 STALL, 2 FLUSH, 3 MEMWAIT.
- `stall_cycles` out CNT_W: saturating count of cycles with `pc_hold`=1.

## Operation
- Scoreboard slots EX, MEM and WB each hold {valid, rd[4:0], is_load}. All slots are invalid after reset.
- Source use, decoded from `id_instruction`:
  - rs1 [19:15] is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 [24:20] is used by BRANCH, STORE and OP (R-type) only.
  - A source equal to x0 never matches.
- Match: a used source equals `rd` of a valid slot.
- The mode is combinational, evaluated in priority order:
  1. MEMWAIT when `mem_req`=1 and `mem_ready`=0. Outputs: `freeze`=1, `pc_hold`=1, `ifid_hold`=1, `stale`=0, `flush`=0. The scoreboard is held and `ex_branch_taken` is ignored. The branch stays in EX because EX is frozen, so it is acted on once the wait ends.
  2. FLUSH when `ex_branch_taken`=1. Outputs: `flush`=1, `stale`=1, no holds. Any pending data hazard is discarded.
  3. STALL on a data hazard (rule depends on configuration). Outputs: `stale`=1, `pc_hold`=1, `ifid_hold`=1.
  4. RUN otherwise. All strobes are 0.
- Scoreboard update, on every edge except in MEMWAIT:
  - WB takes MEM, and MEM takes EX.
  - EX takes {`id_reg_write` && rd!=0, rd [11:7], `id_mem_to_reg`} when `stale`=0. Otherwise EX becomes invalid (bubble).
- `stall_cycles` increments on each edge where `pc_hold`=1 and saturates at all-ones.
- While `rst`=1:
  - Outputs are `stale`=1 and every other strobe 0, with `cause`=0.
  - At the edge, all slots are cleared and `stall_cycles` is set to 0.

## Timing
- All outputs are combinational from the inputs and registered state, valid in the same cycle. There is no added latency.
- A hazard clears after at most 3 stall cycles, because bubbles age the producer out of the slots.
- A simultaneous branch flush and data hazard resolves as FLUSH only. The flushed ID instruction needs no stall.
- A memory wait that starts mid-stall freezes the scoreboard. The stall resumes unchanged afterwards.
- Reset asserted mid-stall or mid-wait takes effect at the next edge. The following cycle is RUN with an empty scoreboard.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - The EX/MEM/WB forwarding network exists.
  - STALL applies only on a match against the EX slot with is_load=1 (load-use), giving a 1-cycle stall.
- `HAZARD_FORWARDING_EN` undefined:
  - STALL applies on a match against any valid EX, MEM or WB slot.
  - The register file is not write-through, so the WB slot is included.

## Test plan
- `lw x5,0(x1)` then `add x6,x5,x2` back-to-back:
  - With forwarding: one cycle of `stale`=`pc_hold`=1 (`cause`=1), `stall_cycles`=1.
  - Without forwarding: 3 stall cycles, `stall_cycles`=3.
- `addi x5,x0,1` then `add x6,x5,x5`:
  - With forwarding: no stall.
  - Without forwarding: 3 stalls.
- `addi x0,x0,1` then `add x6,x0,x0`: no stall in either configuration (x0 never matches).
- `ex_branch_taken`=1 in the same cycle as a load-use match: `flush`=1, `stale`=1, `pc_hold`=0, `cause`=2. The next cycle is RUN.
- `mem_req`=1 with `mem_ready`=0 for 4 cycles while a branch is taken in EX:
  - 4 cycles of `freeze`=`pc_hold`=1, `cause`=3, no flush.
  - Flush occurs in the 5th cycle.
  - `stall_cycles` increases by 4.
- Preload `stall_cycles` to 0xFFFE, then run 3 stall cycles: the counter reads 0xFFFF. Assert `rst` mid-stall: the next cycle reads `stall_cycles`=0 and `cause`=0.
